// File: rtl/coin_acceptor.sv
// Coin acceptor front end: classifies coin-sensor pulse widths, stores accepted coins and
// replays them as a gap-free burst of coin codes once the credit reaches TARGET.
module coin_acceptor #(
    parameter int CNT_W   = 8,
    parameter int W5_MIN  = 4,
    parameter int W5_MAX  = 8,
    parameter int W10_MIN = 12,
    parameter int W10_MAX = 20,
    parameter int TARGET  = 15,
    parameter int TIMEOUT = 1000,
    parameter int TIMER_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_det,
    output logic [1:0] coin_code,
    output logic       code_valid,
    output logic       busy,
    output logic       reject,
    output logic       refund,
    output logic [4:0] refund_amt,
    output logic [4:0] credit
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_BURST   = 2'd2;
    localparam logic [1:0] S_REFUND  = 2'd3;

    localparam int QW = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0]   W5_LO    = CNT_W'(W5_MIN);
    localparam logic [CNT_W-1:0]   W5_HI    = CNT_W'(W5_MAX);
    localparam logic [CNT_W-1:0]   W10_LO   = CNT_W'(W10_MIN);
    localparam logic [CNT_W-1:0]   W10_HI   = CNT_W'(W10_MAX);
    localparam logic [4:0]         TARGET_C = 5'(TARGET);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [QW-1:0]      FULL_C   = QW'(DEPTH);
    localparam logic [QW-1:0]      ONE_Q    = QW'(1);

    // Width-to-code mapping; 2'b00 means the pulse is not a valid coin.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
        logic [1:0] c;
        if (w >= W5_LO && w <= W5_HI) begin
            c = 2'b01;
        end else if (w >= W10_LO && w <= W10_HI) begin
            c = 2'b10;
        end else begin
            c = 2'b00;
        end
        return c;
    endfunction

    function automatic logic [4:0] coin_value(input logic [1:0] c);
        logic [4:0] v;
        case (c)
            2'b01:   v = 5'd5;
            2'b10:   v = 5'd10;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    logic [1:0]         state_r, state_n;
    logic               det_prev_r;
    logic [CNT_W-1:0]   width_r, width_n;
    logic [TIMER_W-1:0] timer_r, timer_n;
    logic [1:0]         fifo_r [DEPTH];
    logic [1:0]         fifo_n [DEPTH];
    logic [QW-1:0]      count_r, count_n;
    logic [4:0]         credit_r, credit_n;
    logic [1:0]         code_n;
    logic [1:0]         coin_s;
    logic               fall_s, busy_s, accept_s, pop_s;

    logic [1:0] coin_code_r;
    logic       code_valid_r, busy_r, reject_r, refund_r;
    logic [4:0] refund_amt_r;

    // Pulse classification, FIFO push/pop and next-state selection.
    always_comb begin
        fall_s   = !coin_det && det_prev_r;
        coin_s   = classify(width_r);
        busy_s   = (state_r == S_BURST) || (state_r == S_REFUND);
        accept_s = fall_s && !busy_s && (coin_s != 2'b00) && (count_r != FULL_C);

        state_n  = state_r;
        fifo_n   = fifo_r;
        count_n  = count_r;
        credit_n = credit_r;
        timer_n  = timer_r;
        code_n   = 2'b00;
        pop_s    = 1'b0;

        if (fall_s) begin
            width_n = '0;
        end else if (coin_det && !(&width_r)) begin
            width_n = width_r + CNT_W'(1);
        end else begin
            width_n = width_r;
        end

        if (accept_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (QW'(i) == count_r) begin
                    fifo_n[i] = coin_s;
                end else begin
                    fifo_n[i] = fifo_n[i];
                end
            end
            count_n  = count_r + ONE_Q;
            credit_n = credit_r + coin_value(coin_s);
        end else begin
            count_n = count_r;
        end

        case (state_r)
            S_IDLE, S_COLLECT: begin
                if (accept_s) begin
                    timer_n = '0;
                    if (credit_n >= TARGET_C) begin
                        state_n = S_BURST;
                        pop_s   = 1'b1;
                    end else begin
                        state_n = S_COLLECT;
                    end
                end else if (state_r == S_COLLECT && !coin_det) begin
                    if (timer_r == TMO_LAST) begin
                        state_n = S_REFUND;
                    end else begin
                        timer_n = timer_r + TIMER_W'(1);
                    end
                end else begin
                    timer_n = timer_r;
                end
            end
            S_BURST: begin
                if (count_r != '0) begin
                    pop_s = 1'b1;
                end else begin
                    state_n  = S_IDLE;
                    credit_n = 5'd0;
                end
            end
            S_REFUND: begin
                count_n  = '0;
                credit_n = 5'd0;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // The head leaves on the same edge it is shown, so a burst entry pops immediately.
        if (pop_s) begin
            code_n = fifo_n[0];
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_n[i] = fifo_n[i + 1];
            end
            fifo_n[DEPTH-1] = 2'b00;
            count_n = count_n - ONE_Q;
        end else begin
            code_n = 2'b00;
        end

        if (state_n != S_COLLECT) begin
            timer_n = '0;
        end else begin
            timer_n = timer_n;
        end
    end

    // State, FIFO, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            det_prev_r   <= 1'b0;
            width_r      <= '0;
            timer_r      <= '0;
            count_r      <= '0;
            credit_r     <= 5'd0;
            coin_code_r  <= 2'b00;
            code_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            reject_r     <= 1'b0;
            refund_r     <= 1'b0;
            refund_amt_r <= 5'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= 2'b00;
            end
        end else begin
            state_r      <= state_n;
            det_prev_r   <= coin_det;
            width_r      <= width_n;
            timer_r      <= timer_n;
            count_r      <= count_n;
            credit_r     <= credit_n;
            fifo_r       <= fifo_n;
            coin_code_r  <= code_n;
            code_valid_r <= (state_n == S_BURST);
            busy_r       <= (state_n == S_BURST) || (state_n == S_REFUND);
            reject_r     <= fall_s && !accept_s;
            refund_r     <= (state_n == S_REFUND);
            refund_amt_r <= (state_n == S_REFUND) ? credit_r : 5'd0;
        end
    end

    assign coin_code  = coin_code_r;
    assign code_valid = code_valid_r;
    assign busy       = busy_r;
    assign reject     = reject_r;
    assign refund     = refund_r;
    assign refund_amt = refund_amt_r;
    assign credit     = credit_r;

endmodule
